// File: rtl/dram_dq_sched_pkg.sv
// Shared types and constants for the DQ read/write scheduler.
//   sched_state_e : scheduler FSM state encoding
//   BEATS_*       : data beats per burst length
//   RD_SYNC_LAT   : fixed capture + resync delay on the read return path
//   *_LAT_MIN/MAX : legal command-to-data latency window
package dram_dq_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_WAIT,
    WR_BURST,
    RD_WAIT,
    RD_BURST,
    RD_DRAIN,
    TURN
  } sched_state_e;

  localparam int unsigned BEATS_BL4   = 2;
  localparam int unsigned BEATS_BL8   = 4;
  localparam int unsigned RD_SYNC_LAT = 2;

  localparam logic [2:0] RD_LAT_MIN = 3'd2;
  localparam logic [2:0] RD_LAT_MAX = 3'd7;
  localparam logic [2:0] WR_LAT_MIN = 3'd1;
  localparam logic [2:0] WR_LAT_MAX = 3'd7;

  // Pull an out-of-range latency back to the nearest legal bound.
  function automatic logic [2:0] clamp_lat(input logic [2:0] lat,
                                           input logic [2:0] lo,
                                           input logic [2:0] hi);
    logic [2:0] r;
    r = lat;
    if (lat < lo) r = lo;
    if (lat > hi) r = hi;
    return r;
  endfunction

  // Burst beat count minus one, used as a down-counter load value.
  function automatic logic [2:0] beats_m1(input logic bl4);
    return bl4 ? 3'(BEATS_BL4 - 1) : 3'(BEATS_BL8 - 1);
  endfunction

endpackage

// File: rtl/dram_dq_slot_cnt.sv
// Capture-slot pointer for the read data path. Free-running 2-bit count that
// advances once per valid read beat and only reloads on reset, so it stays
// aligned with the pad-side capture pointer across commands.
//   clk_i    : DRAM-domain clock
//   arst_l_i : asynchronous active-low reset
//   inc_i    : advance the pointer at the next edge
//   slot_o   : current capture slot (reset value 1)
module dram_dq_slot_cnt (
  input  logic       clk_i,
  input  logic       arst_l_i,
  input  logic       inc_i,
  output logic [1:0] slot_o
);

  logic [1:0] slot_q, slot_d;

  always_comb begin
    slot_d = slot_q;
    if (inc_i) slot_d = slot_q + 2'd1;
  end

  always_ff @(posedge clk_i or negedge arst_l_i) begin
    if (!arst_l_i) slot_q <= 2'b01;
    else           slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/dram_dq_rdwr_sched.sv
// DQ read/write scheduler. Accepts one read or write command at a time from
// IDLE, then times the DQ drive window (writes) or the pad capture window and
// the delayed data-valid window (reads) off a single latency/beat down-counter.
//   clk, arst_l                  : clock, async active-low reset
//   cfg_burst_four               : 1 = BL4 (2 beats), 0 = BL8 (4 beats)
//   cfg_rd_lat / cfg_wr_lat      : accept-to-data latency (clamped to legal)
//   cfg_turn                     : idle cycles after a read
//   rd_req / wr_req              : command requests, held until acked
//   rd_ack / wr_ack              : one-cycle accept pulses
//   dram_io_drive_enable         : write drive window
//   dram_io_pad_enable           : read capture window
//   burst_length_four            : burst length latched at accept
//   pad_pos_cnt / pad_neg_cnt    : capture slot select (identical)
//   rd_data_vld                  : read data valid
//   busy                         : not in IDLE
//
// state    | meaning
// IDLE     | waiting for a request, arbitration happens here
// WR_WAIT  | write accepted, counting down write latency
// WR_BURST | driving DQ, counting down beats
// RD_WAIT  | read accepted, counting down read latency
// RD_BURST | pad capture window open, counting down beats
// RD_DRAIN | last beats emerging from the capture/resync pipe
// TURN     | read-to-next-command bus turnaround
module dram_dq_rdwr_sched
  import dram_dq_sched_pkg::*;
(
  input  logic       clk,
  input  logic       arst_l,
  input  logic       cfg_burst_four,
  input  logic [2:0] cfg_rd_lat,
  input  logic [2:0] cfg_wr_lat,
  input  logic [1:0] cfg_turn,
  input  logic       rd_req,
  input  logic       wr_req,
  output logic       rd_ack,
  output logic       wr_ack,
  output logic       dram_io_drive_enable,
  output logic       dram_io_pad_enable,
  output logic       burst_length_four,
  output logic [1:0] pad_pos_cnt,
  output logic [1:0] pad_neg_cnt,
  output logic       rd_data_vld,
  output logic       busy
);

  sched_state_e state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         bl4_q, bl4_d;
  logic [1:0]   turn_q, turn_d;
  logic         last_wr_q, last_wr_d;

  logic rd_ack_q, rd_ack_d;
  logic wr_ack_q, wr_ack_d;
  logic drv_q, drv_d;
  logic pad_q, pad_d;
  logic vld_q, vld_d;
  logic busy_q, busy_d;

  logic       grant_rd, grant_wr;
  logic [3:0] vld_cnt_lim;
  logic [1:0] slot;

  // Round-robin between the two types only matters when both are pending.
  always_comb begin
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    if (state_q == IDLE) begin
      grant_rd = rd_req & (~wr_req | last_wr_q);
      grant_wr = wr_req & ~grant_rd;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bl4_d     = bl4_q;
    turn_d    = turn_q;
    last_wr_d = last_wr_q;
    case (state_q)
      IDLE: begin
        if (grant_rd) begin
          state_d   = RD_WAIT;
          cnt_d     = clamp_lat(cfg_rd_lat, RD_LAT_MIN, RD_LAT_MAX) - 3'd1;
          bl4_d     = cfg_burst_four;
          turn_d    = cfg_turn;
          last_wr_d = 1'b0;
        end else if (grant_wr) begin
          state_d   = WR_WAIT;
          cnt_d     = clamp_lat(cfg_wr_lat, WR_LAT_MIN, WR_LAT_MAX) - 3'd1;
          bl4_d     = cfg_burst_four;
          turn_d    = cfg_turn;
          last_wr_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = WR_BURST;
          cnt_d   = beats_m1(bl4_q);
        end else cnt_d = cnt_q - 3'd1;
      end
      WR_BURST: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      RD_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RD_BURST;
          cnt_d   = beats_m1(bl4_q);
        end else cnt_d = cnt_q - 3'd1;
      end
      RD_BURST: begin
        if (cnt_q == 3'd0) begin
          state_d = RD_DRAIN;
          cnt_d   = 3'(RD_SYNC_LAT - 1);
        end else cnt_d = cnt_q - 3'd1;
      end
      RD_DRAIN: begin
        if (cnt_q == 3'd0) begin
          if (turn_q == 2'd0) state_d = IDLE;
          else begin
            state_d = TURN;
            cnt_d   = {1'b0, turn_q} - 3'd1;
          end
        end else cnt_d = cnt_q - 3'd1;
      end
      TURN: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid trails the pad window by RD_SYNC_LAT, so inside RD_BURST it is only
  // high once that many beats have gone by (beat counter below beats-sync).
  assign vld_cnt_lim = {1'b0, beats_m1(bl4_q)} + 4'd1 - 4'(RD_SYNC_LAT);

  always_comb begin
    rd_ack_d = grant_rd;
    wr_ack_d = grant_wr;
    drv_d    = (state_d == WR_BURST);
    pad_d    = (state_d == RD_BURST);
    vld_d    = (state_d == RD_DRAIN) |
               ((state_d == RD_BURST) & ({1'b0, cnt_d} < vld_cnt_lim));
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      bl4_q     <= 1'b0;
      turn_q    <= 2'd0;
      last_wr_q <= 1'b1;
      rd_ack_q  <= 1'b0;
      wr_ack_q  <= 1'b0;
      drv_q     <= 1'b0;
      pad_q     <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bl4_q     <= bl4_d;
      turn_q    <= turn_d;
      last_wr_q <= last_wr_d;
      rd_ack_q  <= rd_ack_d;
      wr_ack_q  <= wr_ack_d;
      drv_q     <= drv_d;
      pad_q     <= pad_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
    end
  end

  dram_dq_slot_cnt u_slot_cnt (
    .clk_i    (clk),
    .arst_l_i (arst_l),
    .inc_i    (vld_q),
    .slot_o   (slot)
  );

  assign rd_ack               = rd_ack_q;
  assign wr_ack               = wr_ack_q;
  assign dram_io_drive_enable = drv_q;
  assign dram_io_pad_enable   = pad_q;
  assign burst_length_four    = bl4_q;
  assign rd_data_vld          = vld_q;
  assign busy                 = busy_q;
  assign pad_pos_cnt          = slot;
  assign pad_neg_cnt          = slot;

endmodule

// File: tb/tb_dram_dq_rdwr_sched.sv
module tb_dram_dq_rdwr_sched;

  logic       clk = 1'b0;
  logic       arst_l;
  logic       cfg_burst_four;
  logic [2:0] cfg_rd_lat, cfg_wr_lat;
  logic [1:0] cfg_turn;
  logic       rd_req, wr_req;
  logic       rd_ack, wr_ack;
  logic       dram_io_drive_enable, dram_io_pad_enable;
  logic       burst_length_four;
  logic [1:0] pad_pos_cnt, pad_neg_cnt;
  logic       rd_data_vld, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_dq_rdwr_sched dut (
    .clk                  (clk),
    .arst_l               (arst_l),
    .cfg_burst_four       (cfg_burst_four),
    .cfg_rd_lat           (cfg_rd_lat),
    .cfg_wr_lat           (cfg_wr_lat),
    .cfg_turn             (cfg_turn),
    .rd_req               (rd_req),
    .wr_req               (wr_req),
    .rd_ack               (rd_ack),
    .wr_ack               (wr_ack),
    .dram_io_drive_enable (dram_io_drive_enable),
    .dram_io_pad_enable   (dram_io_pad_enable),
    .burst_length_four    (burst_length_four),
    .pad_pos_cnt          (pad_pos_cnt),
    .pad_neg_cnt          (pad_neg_cnt),
    .rd_data_vld          (rd_data_vld),
    .busy                 (busy)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Schedule model: on each accept, mark the cycles in which every output
  // must be high, directly from the latency/beat/turn arithmetic.
  localparam int RS = 64;
  bit e_ack_r [RS];
  bit e_ack_w [RS];
  bit e_drv   [RS];
  bit e_pad   [RS];
  bit e_vld   [RS];
  bit e_busy  [RS];
  int cyc       = 0;
  int next_free = 0;
  int exp_cnt   = 1;
  bit last_wr   = 1'b1;
  int exp_bl4   = 0;
  bit m_rd;
  int m_l, m_b, m_end;

  always @(posedge clk or negedge arst_l) begin
    if (!arst_l) begin
      for (int i = 0; i < RS; i++) begin
        e_ack_r[i] = 0; e_ack_w[i] = 0; e_drv[i] = 0;
        e_pad[i] = 0; e_vld[i] = 0; e_busy[i] = 0;
      end
      exp_cnt = 1; next_free = 0; last_wr = 1'b1; exp_bl4 = 0;
    end else begin
      exp_cnt = (exp_cnt + int'(e_vld[cyc % RS])) % 4;
      cyc++;
      e_ack_r[(cyc + 40) % RS] = 0; e_ack_w[(cyc + 40) % RS] = 0;
      e_drv[(cyc + 40) % RS] = 0;   e_pad[(cyc + 40) % RS] = 0;
      e_vld[(cyc + 40) % RS] = 0;   e_busy[(cyc + 40) % RS] = 0;
      if (cyc >= next_free && (rd_req || wr_req)) begin
        m_rd    = rd_req && (!wr_req || last_wr);
        last_wr = !m_rd;
        exp_bl4 = int'(cfg_burst_four);
        m_b     = cfg_burst_four ? 2 : 4;
        if (m_rd) begin
          m_l   = (cfg_rd_lat < 2) ? 2 : int'(cfg_rd_lat);
          m_end = cyc + m_l + m_b + 2 + int'(cfg_turn);
          e_ack_r[cyc % RS] = 1;
          for (int k = 0; k < m_b; k++) begin
            e_pad[(cyc + m_l + k) % RS]     = 1;
            e_vld[(cyc + m_l + 2 + k) % RS] = 1;
          end
        end else begin
          m_l   = (cfg_wr_lat < 1) ? 1 : int'(cfg_wr_lat);
          m_end = cyc + m_l + m_b;
          e_ack_w[cyc % RS] = 1;
          for (int k = 0; k < m_b; k++) e_drv[(cyc + m_l + k) % RS] = 1;
        end
        for (int c = cyc; c < m_end; c++) e_busy[c % RS] = 1;
        next_free = m_end + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (arst_l) begin
      chk($sformatf("m_rd_ack@%0d", cyc), int'(rd_ack), int'(e_ack_r[cyc % RS]));
      chk($sformatf("m_wr_ack@%0d", cyc), int'(wr_ack), int'(e_ack_w[cyc % RS]));
      chk($sformatf("m_drv@%0d", cyc), int'(dram_io_drive_enable), int'(e_drv[cyc % RS]));
      chk($sformatf("m_pad@%0d", cyc), int'(dram_io_pad_enable), int'(e_pad[cyc % RS]));
      chk($sformatf("m_vld@%0d", cyc), int'(rd_data_vld), int'(e_vld[cyc % RS]));
      chk($sformatf("m_busy@%0d", cyc), int'(busy), int'(e_busy[cyc % RS]));
      chk($sformatf("m_bl4@%0d", cyc), int'(burst_length_four), exp_bl4);
      chk($sformatf("m_pos@%0d", cyc), int'(pad_pos_cnt), exp_cnt);
      chk($sformatf("m_neg@%0d", cyc), int'(pad_neg_cnt), exp_cnt);
      chk($sformatf("m_overlap@%0d", cyc),
          int'(dram_io_drive_enable & dram_io_pad_enable), 0);
    end
  end

  int cnt_hist [32];

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_rd_ack"}, int'(rd_ack), 0);
    chk({nm, "_wr_ack"}, int'(wr_ack), 0);
    chk({nm, "_drv"}, int'(dram_io_drive_enable), 0);
    chk({nm, "_pad"}, int'(dram_io_pad_enable), 0);
    chk({nm, "_vld"}, int'(rd_data_vld), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_bl4"}, int'(burst_length_four), 0);
    chk({nm, "_pos"}, int'(pad_pos_cnt), 1);
    chk({nm, "_neg"}, int'(pad_neg_cnt), 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 arst_l = 1'b0;
    #1 chk_reset_outs("rst");
    repeat (2) @(negedge clk);
    #1 arst_l = 1'b1;
  endtask

  // Caller raises the request before the next edge (cycle 0 = accept edge).
  task automatic observe(input string nm, input bit is_rd, input int n,
                         input logic [31:0] x_drv, input logic [31:0] x_pad,
                         input logic [31:0] x_vld, input logic [31:0] x_busy,
                         input int x_bl4, input int new_rd_lat);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      cnt_hist[k] = int'(pad_pos_cnt);
      if (k == 0) begin
        chk({nm, "_ack"}, int'(is_rd ? rd_ack : wr_ack), 1);
        chk({nm, "_bl4"}, int'(burst_length_four), x_bl4);
      end
      chk($sformatf("%s_drv%0d", nm, k), int'(dram_io_drive_enable), int'(x_drv[k]));
      chk($sformatf("%s_pad%0d", nm, k), int'(dram_io_pad_enable), int'(x_pad[k]));
      chk($sformatf("%s_vld%0d", nm, k), int'(rd_data_vld), int'(x_vld[k]));
      chk($sformatf("%s_busy%0d", nm, k), int'(busy), int'(x_busy[k]));
      if (rd_ack) rd_req = 1'b0;
      if (wr_ack) wr_req = 1'b0;
      if (k == 0 && new_rd_lat >= 0) cfg_rd_lat = 3'(new_rd_lat);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    chk({nm, "_idle_wait"}, int'(ok), 1);
  endtask

  int ord [4];
  int n_acks;
  int q_cnt [$];
  bit seen;
  int exp_seq [5];

  initial begin
    arst_l = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    cfg_burst_four = 1'b0; cfg_rd_lat = 3'd4; cfg_wr_lat = 3'd3; cfg_turn = 2'd0;
    repeat (3) @(negedge clk);
    chk_reset_outs("por");
    #1 arst_l = 1'b1;

    // BL4 write, wr_lat 3: drive 3-4, idle at 5
    cfg_burst_four = 1'b1; cfg_wr_lat = 3'd3; wr_req = 1'b1;
    observe("wr_bl4", 1'b0, 7, 32'h18, 32'h0, 32'h0, 32'h1F, 1, -1);

    // BL8 read, rd_lat 4, turn 2: pad 4-7, vld 6-9, turn 10-11, idle 12
    cfg_burst_four = 1'b0; cfg_rd_lat = 3'd4; cfg_turn = 2'd2; rd_req = 1'b1;
    observe("rd_bl8", 1'b1, 14, 32'h0, 32'hF0, 32'h3C0, 32'hFFF, 0, -1);
    chk("rd_bl8_cnt5", cnt_hist[5], 1);
    chk("rd_bl8_cnt6", cnt_hist[6], 1);
    chk("rd_bl8_cnt7", cnt_hist[7], 2);
    chk("rd_bl8_cnt8", cnt_hist[8], 3);
    chk("rd_bl8_cnt9", cnt_hist[9], 0);
    chk("rd_bl8_cnt10", cnt_hist[10], 1);

    // Both requests held from reset, with clamped latencies: R,W,R,W
    cfg_burst_four = 1'b0; cfg_rd_lat = 3'd1; cfg_wr_lat = 3'd0; cfg_turn = 2'd1;
    @(negedge clk);
    #1 arst_l = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
    repeat (2) @(negedge clk);
    #1 arst_l = 1'b1;
    n_acks = 0;
    for (int i = 0; i < 300 && n_acks < 4; i++) begin
      @(negedge clk);
      if (rd_ack) begin ord[n_acks] = 1; n_acks++; end
      else if (wr_ack) begin ord[n_acks] = 0; n_acks++; end
    end
    rd_req = 1'b0; wr_req = 1'b0;
    chk("alt_ack_count", n_acks, 4);
    for (int i = 0; i < n_acks; i++)
      chk($sformatf("alt_ack_type%0d", i), ord[i], (i % 2 == 0) ? 1 : 0);
    wait_idle("alt");

    // Two BL4 reads back to back: slot sequence 1,2,3,0 then 1
    do_reset();
    cfg_burst_four = 1'b1; cfg_rd_lat = 3'd2; cfg_turn = 2'd0; rd_req = 1'b1;
    n_acks = 0;
    q_cnt.delete();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rd_data_vld) q_cnt.push_back(int'(pad_pos_cnt));
      if (rd_ack) n_acks++;
      if (n_acks == 2) rd_req = 1'b0;
      if (n_acks == 2 && !busy) break;
    end
    rd_req = 1'b0;
    q_cnt.push_back(int'(pad_pos_cnt));
    chk("b2b_acks", n_acks, 2);
    chk("b2b_len", q_cnt.size(), 5);
    exp_seq = '{1, 2, 3, 0, 1};
    for (int i = 0; i < 5 && i < q_cnt.size(); i++)
      chk($sformatf("b2b_cnt%0d", i), q_cnt[i], exp_seq[i]);

    // Reset during a BL8 read pad window aborts; reacked on first edge after
    cfg_burst_four = 1'b0; cfg_rd_lat = 3'd4; cfg_turn = 2'd0; rd_req = 1'b1;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rd_ack) rd_req = 1'b0;
      if (dram_io_pad_enable) begin seen = 1; break; end
    end
    chk("abort_pad_seen", int'(seen), 1);
    #2 arst_l = 1'b0;
    #1 chk_reset_outs("abort");
    rd_req = 1'b1;
    @(negedge clk);
    chk_reset_outs("abort_held");
    #1 arst_l = 1'b1;
    @(negedge clk);
    chk("abort_reack", int'(rd_ack), 1);
    rd_req = 1'b0;
    wait_idle("abort");

    // cfg_rd_lat changed after accept must not move the windows
    cfg_burst_four = 1'b1; cfg_rd_lat = 3'd4; cfg_turn = 2'd1; rd_req = 1'b1;
    observe("lat_chg", 1'b1, 11, 32'h0, 32'h30, 32'hC0, 32'h1FF, 1, 7);

    // BL8 write with wr_lat 0 clamps to 1: drive 1-4, idle at 5
    cfg_burst_four = 1'b0; cfg_wr_lat = 3'd0; wr_req = 1'b1;
    observe("wr_clamp", 1'b0, 7, 32'h1E, 32'h0, 32'h0, 32'h1F, 0, -1);

    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
